// File: rtl/xgmii_tx_arbiter_pkg.sv
// Shared XGMII column constants, FIFO word layout and scheduler state encoding
// for the l2switch transmit path.
package xgmii_tx_arbiter_pkg;

    localparam logic [63:0] XGMII_IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  XGMII_IDLE_C = 8'hff;
    localparam logic [63:0] XGMII_ERR_D  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [7:0]  XGMII_ERR_C  = 8'hff;
    localparam int          EOP_BIT      = 72;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XMIT,
        ST_DRAIN,
        ST_IFG
    } state_t;

    // Forwarding FIFO head word: {eop, txc, txd}
    typedef struct packed {
        logic        eop;
        logic [7:0]  txc;
        logic [63:0] txd;
    } fifo_word_t;

endpackage

// File: rtl/xgmii_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first request strictly
// after ptr, wrapping. The caller owns and updates ptr.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic w_found;

    always_comb begin
        gnt     = '0;
        w_found = 1'b0;
        // k is the distance from ptr; the nearest requester wins
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!w_found && req[i] && (i == ((int'(ptr) + k) % N))) begin
                    gnt[i]  = 1'b1;
                    w_found = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/xgmii_tx_arbiter.sv
// Packet-level round-robin scheduler sharing one XGMII TX port among NPORT
// FWFT forwarding FIFOs, with IFG insertion and underrun-to-error handling.
module xgmii_tx_arbiter
    import xgmii_tx_arbiter_pkg::*;
#(
    parameter int NPORT      = 3,
    parameter int IFG_CYCLES = 1,
    parameter int WORD_W     = 73
) (
    input  logic                    sys_clk,
    input  logic                    sys_rst_n,
    input  logic [NPORT-1:0]        port_en,
    input  logic [NPORT-1:0]        req_empty,
    input  logic [NPORT*WORD_W-1:0] req_data,
    output logic [NPORT-1:0]        req_rd_en,
    output logic [63:0]             xgmii_txd,
    output logic [7:0]              xgmii_txc,
    output logic [NPORT-1:0]        grant,
    output logic                    underrun,
    output logic                    busy
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES + 1) : 1;

    state_t           r_state, w_state_nxt;
    logic [PW-1:0]    r_ptr, w_ptr_nxt;
    logic [NPORT-1:0] r_grant, w_grant_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;
    logic [63:0]      r_txd, w_txd_nxt;
    logic [7:0]       r_txc, w_txc_nxt;
    logic             r_underrun, w_underrun_nxt;

    logic [NPORT-1:0]  w_eligible, w_arb_gnt, w_rd_en;
    logic [PW-1:0]     w_win_idx;
    logic [WORD_W-1:0] w_sel;
    fifo_word_t        w_head;
    logic              w_gempty;

    assign w_eligible = port_en & ~req_empty;

    rr_arbiter #(.N(NPORT), .PW(PW)) u_rr (
        .req (w_eligible),
        .ptr (r_ptr),
        .gnt (w_arb_gnt)
    );

    always_comb begin
        w_win_idx = '0;
        for (int i = 0; i < NPORT; i++)
            if (w_arb_gnt[i]) w_win_idx = PW'(i);
    end

    // Grant is one-hot while a packet is owned, so the head mux is an OR-select
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NPORT; i++)
            if (r_grant[i]) w_sel = req_data[i*WORD_W +: WORD_W];
    end

    assign w_head   = fifo_word_t'(w_sel[EOP_BIT:0]);
    assign w_gempty = |(r_grant & req_empty);

    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_grant_nxt    = r_grant;
        w_cnt_nxt      = r_cnt;
        w_txd_nxt      = XGMII_IDLE_D;
        w_txc_nxt      = XGMII_IDLE_C;
        w_underrun_nxt = 1'b0;
        w_rd_en        = '0;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_grant_nxt = w_arb_gnt;
                    w_ptr_nxt   = w_win_idx;
                    w_state_nxt = ST_XMIT;
                end
            end
            ST_XMIT: begin
                if (!w_gempty) begin
                    w_rd_en   = r_grant;
                    w_txd_nxt = w_head.txd;
                    w_txc_nxt = w_head.txc;
                end else begin
                    w_txd_nxt      = XGMII_ERR_D;
                    w_txc_nxt      = XGMII_ERR_C;
                    w_underrun_nxt = 1'b1;
                    w_state_nxt    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Remainder of a broken packet is discarded without reaching the line
                if (!w_gempty) w_rd_en = r_grant;
            end
            ST_IFG: begin
                w_cnt_nxt = r_cnt - CW'(1);
                if (r_cnt == CW'(1)) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if ((r_state == ST_XMIT || r_state == ST_DRAIN) && !w_gempty && w_head.eop) begin
            w_grant_nxt = '0;
            if (IFG_CYCLES == 0) begin
                w_state_nxt = ST_IDLE;
            end else begin
                w_state_nxt = ST_IFG;
                w_cnt_nxt   = CW'(IFG_CYCLES);
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= PW'(NPORT - 1);
            r_grant    <= '0;
            r_cnt      <= '0;
            r_txd      <= XGMII_IDLE_D;
            r_txc      <= XGMII_IDLE_C;
            r_underrun <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_grant    <= w_grant_nxt;
            r_cnt      <= w_cnt_nxt;
            r_txd      <= w_txd_nxt;
            r_txc      <= w_txc_nxt;
            r_underrun <= w_underrun_nxt;
        end
    end

    assign req_rd_en = w_rd_en;
    assign xgmii_txd = r_txd;
    assign xgmii_txc = r_txc;
    assign grant     = r_grant;
    assign underrun  = r_underrun;
    assign busy      = (r_state != ST_IDLE);

endmodule
